dec_unbinder: RTL

DEC_UNBINDER -- requirements
Module: dec_unbinder

---
 rtl/dec_unbinder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dec_unbinder.sv
// dec_unbinder: undoes the binder's cyclic rotation on a bound hypervector and
// classifies the result against a bank of level hypervectors. The level with
// the largest overlap (popcount of AND) wins; ties keep the lower index.
//
// Ports
//   clk            sole clock, rising edge
//   nrst           asynchronous reset, active high
//   start_decoding accept a new decode when idle (ignored while busy)
//   bound_hv       bound (rotated) hypervector, captured at acceptance
//   shift_amt      rotation applied by the encoder, captured at acceptance
//   level_hv       level item memory; must stay stable from start to done
//   busy           high in every non-idle state
//   done           one-cycle pulse, level_idx/score valid from this cycle
//   unshifted_hv   registered inverse-rotated vector
//   level_idx      index of the best-matching level
//   score          overlap count of the best match
module dec_unbinder #(
  parameter  int HV_DIM     = 1024,
  parameter  int NUM_LEVELS = 10,
  localparam int SW         = $clog2(HV_DIM),
  localparam int LW         = $clog2(NUM_LEVELS),
  localparam int SCW        = $clog2(HV_DIM + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_decoding,
  input  logic [HV_DIM-1:0] bound_hv,
  input  logic [SW-1:0]     shift_amt,
  input  logic [HV_DIM-1:0] level_hv [0:NUM_LEVELS-1],
  output logic              busy,
  output logic              done,
  output logic [HV_DIM-1:0] unshifted_hv,
  output logic [LW-1:0]     level_idx,
  output logic [SCW-1:0]    score
);

  // Counter runs 0..NUM_LEVELS: NUM_LEVELS popcount issues plus one final
  // compare slot, since the overlap is registered before it is compared.
  localparam int            CW   = $clog2(NUM_LEVELS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_LEVELS);

  typedef enum logic [1:0] {IDLE, UNBIND, SEARCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [HV_DIM-1:0]  bound_q;
  logic [SW-1:0]      shift_q;
  logic [CW-1:0]      cnt_q;
  logic [SCW-1:0]     pop_q;
  logic [SCW-1:0]     best_score_q;
  logic [LW-1:0]      best_idx_q;

  logic [31:0]        s_mod;
  logic [2*HV_DIM-1:0] dbl;
  logic [HV_DIM-1:0]  unbind_hv;
  logic [HV_DIM-1:0]  lvl_sel;
  logic [SCW-1:0]     ov;
  logic [LW-1:0]      cand_idx;
  logic [SCW-1:0]     nxt_score;
  logic [LW-1:0]      nxt_idx;

  function automatic logic [SCW-1:0] popcnt(input logic [HV_DIM-1:0] v);
    logic [SCW-1:0] c;
    c = '0;
    for (int i = 0; i < HV_DIM; i++) c = c + SCW'(v[i]);
    return c;
  endfunction

  // Inverse rotation: out[j] = in[(j+S) mod D]. Shifting a doubled copy right
  // by S (S < D) leaves exactly that in the low D bits.
  always_comb begin
    s_mod     = 32'(shift_q) % 32'(HV_DIM);
    dbl       = {bound_q, bound_q} >> s_mod;
    unbind_hv = dbl[HV_DIM-1:0];
  end

  // Level lookup is only live while issuing; the compare-only slot sees zero.
  always_comb begin
    lvl_sel = '0;
    if (state_q == SEARCH && cnt_q < LAST) lvl_sel = level_hv[cnt_q[LW-1:0]];
    ov = popcnt(unshifted_hv & lvl_sel);
  end

  // Running best; pop_q holds the overlap of level cnt_q-1. Strict compare
  // keeps the earlier index on ties.
  always_comb begin
    cand_idx  = LW'(cnt_q - CW'(1));
    nxt_score = best_score_q;
    nxt_idx   = best_idx_q;
    if (cnt_q != '0 && pop_q > best_score_q) begin
      nxt_score = pop_q;
      nxt_idx   = cand_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start_decoding) state_d = UNBIND;
      end
      UNBIND: state_d = SEARCH;
      SEARCH: if (cnt_q == LAST) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q      <= IDLE;
      bound_q      <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      pop_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      unshifted_hv <= '0;
      level_idx    <= '0;
      score        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_decoding) begin
          bound_q <= bound_hv;
          shift_q <= shift_amt;
        end
        UNBIND: begin
          unshifted_hv <= unbind_hv;
          best_score_q <= '0;
          best_idx_q   <= '0;
          cnt_q        <= '0;
        end
        SEARCH: begin
          if (cnt_q < LAST) pop_q <= ov;
          best_score_q <= nxt_score;
          best_idx_q   <= nxt_idx;
          if (cnt_q == LAST) begin
            // Results publish only here, on entry to DONE.
            level_idx <= nxt_idx;
            score     <= nxt_score;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
